// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// First-word-fall-through FIFO controller wrapped around an external
// dual-port RAM with a registered read port (one-cycle read latency).
// The RAM read register is the FIFO output stage, so dataout is a plain
// wire from ram_rdata and is valid whenever empty is low.
//
// Optional feature: define FIFO_CTRL_ERR_EN to get sticky overflow /
// underflow flags. Without it both outputs are tied low and no extra
// registers are built.
module dpram_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] datain,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] dataout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int              SIZE_I  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] SIZE    = SIZE_I[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  // Pointers wrap naturally mod 2^ADDR_W; occupancy comes from counts only.
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [ADDR_W:0]   ram_count_q, ram_count_d;
  logic              dout_valid_q, dout_valid_d;

  logic wr_acc;
  logic rd_acc;
  logic fetch;

  // Status and handshake decode from the current state.
  always_comb begin
    usedw   = ram_count_q + {{ADDR_W{1'b0}}, dout_valid_q};
    full    = (usedw == SIZE);
    empty   = ~dout_valid_q;
    wr_acc  = write & ~full;
    rd_acc  = read & dout_valid_q;
    // Refill the output register whenever it is free or being popped now.
    fetch   = (ram_count_q != '0) & (~dout_valid_q | rd_acc);
  end

  // RAM-side drive. Holding head_addr when not fetching keeps ram_rdata
  // stable; that slot cannot be rewritten until it has been popped.
  always_comb begin
    ram_waddr = wr_ptr_q;
    ram_wdata = datain;
    ram_wen   = wr_acc;
    ram_raddr = fetch ? rd_ptr_q : head_addr_q;
    dataout   = ram_rdata;
  end

  // Next-state logic; clear overrides any write/read in the same cycle.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_addr_d  = head_addr_q;
    ram_count_d  = ram_count_q;
    dout_valid_d = dout_valid_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (fetch) begin
      head_addr_d  = rd_ptr_q;
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      dout_valid_d = 1'b1;
    end else if (rd_acc) begin
      dout_valid_d = 1'b0;
    end

    // ram_count only counts completed writes, so a slot is never fetched
    // in the same cycle it is written.
    case ({wr_acc, fetch})
      2'b10:   ram_count_d = ram_count_q + CNT_ONE;
      2'b01:   ram_count_d = ram_count_q - CNT_ONE;
      default: ram_count_d = ram_count_q;
    endcase

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      head_addr_d  = '0;
      ram_count_d  = '0;
      dout_valid_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_addr_q  <= '0;
      ram_count_q  <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_addr_q  <= head_addr_d;
      ram_count_q  <= ram_count_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set on write-while-full / read-while-empty.
  always_comb begin
    overflow_d  = overflow_q  | (write & full);
    underflow_d = underflow_q | (read & empty);
    if (clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Error flag register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Testbench for dpram_fifo_ctrl: behavioural registered-read RAM plus a
// scoreboard queue of accepted words tagged with the cycle they were written.
module tb_dpram_fifo_ctrl;

  localparam int SZ = 16;
`ifdef FIFO_CTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, clear, write, read;
  logic [15:0] datain, dataout, ram_wdata, ram_rdata;
  logic        empty, full, overflow, underflow, ram_wen;
  logic [4:0]  usedw;
  logic [3:0]  ram_waddr, ram_raddr;
  logic [15:0] mem [SZ];

  dpram_fifo_ctrl #(.ADDR_W(4), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .clear(clear), .datain(datain),
    .write(write), .read(read), .dataout(dataout), .empty(empty),
    .full(full), .usedw(usedw), .overflow(overflow), .underflow(underflow),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // External RAM: write port plus registered read port.
  always @(posedge clock) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  typedef struct { logic [15:0] d; int c; } ent_t;
  ent_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  // A word written in cycle c is on dataout from cycle c+2 when it is at the head.
  function automatic logic head_vis();
    return (sb.size() > 0) && (sb[0].c + 2 <= cyc);
  endfunction

  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
    logic vis, wacc, racc;
    ent_t e;
    write = w; datain = d; read = r; clear = c;
    #1;
    vis  = head_vis();
    wacc = w && (sb.size() < SZ) && !c;
    racc = r && vis && !c;
    checks++;
    if (empty !== !vis) begin
      errors++; $display("FAIL step_empty cyc=%0d got=%b exp=%b", cyc, empty, !vis);
    end
    checks++;
    if (usedw !== 5'(sb.size())) begin
      errors++; $display("FAIL step_usedw cyc=%0d got=%0d exp=%0d", cyc, usedw, sb.size());
    end
    checks++;
    if (ram_wen !== (w && (sb.size() < SZ))) begin
      errors++; $display("FAIL step_wen cyc=%0d got=%b", cyc, ram_wen);
    end
    checks++;
    if (overflow !== (ERR_EN & m_ovf) || underflow !== (ERR_EN & m_udf)) begin
      errors++; $display("FAIL step_errflags cyc=%0d got=%b%b exp=%b%b", cyc,
                         overflow, underflow, ERR_EN & m_ovf, ERR_EN & m_udf);
    end
    if (racc) begin
      checks++;
      if (dataout !== sb[0].d) begin
        errors++; $display("FAIL pop_data cyc=%0d got=%h exp=%h", cyc, dataout, sb[0].d);
      end
    end
    @(posedge clock);
    if (c) begin
      sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (w && sb.size() >= SZ) m_ovf = 1'b1;
      if (r && !vis) m_udf = 1'b1;
      if (racc) void'(sb.pop_front());
      if (wacc) begin e.d = d; e.c = cyc; sb.push_back(e); end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; write = 1'b0; read = 1'b0; clear = 1'b0; datain = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (usedw !== 5'd0) begin errors++; $display("FAIL rst_usedw got=%0d exp=0", usedw); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL rst_errflags got=%b%b exp=00", overflow, underflow); end
    checks++; if (ram_raddr !== 4'd0 || ram_waddr !== 4'd0) begin
      errors++; $display("FAIL rst_addr got=%0d/%0d exp=0/0", ram_raddr, ram_waddr); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got=%b exp=0", ram_wen); end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_n1_empty got=%b exp=1", empty); end
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_n2_empty got=%b exp=0", empty); end
    checks++; if (dataout !== 16'h0001) begin errors++; $display("FAIL single_data got=%h exp=0001", dataout); end
    checks++; if (usedw !== 5'd1) begin errors++; $display("FAIL single_usedw got=%0d exp=1", usedw); end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin
      errors++; $display("FAIL single_after_read got=%b/%0d exp=1/0", empty, usedw); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || usedw !== 5'd16) begin
      errors++; $display("FAIL fill_full got=%b/%0d exp=1/16", full, usedw); end
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    checks++; if (overflow !== ERR_EN || usedw !== 5'd16) begin
      errors++; $display("FAIL fill_overflow got=%b/%0d exp=%b/16", overflow, usedw, ERR_EN); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (empty !== 1'b0 || dataout !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL drain_word%0d got=%b/%h exp=0/%h", i, empty, dataout, 16'h0100 + 16'(i));
      end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (usedw !== 5'd4) begin errors++; $display("FAIL stream_usedw i=%0d got=%0d exp=4", i, usedw); end
      step(1'b1, 16'h2004 + 16'(i), 1'b1, 1'b0);
    end
    checks++; if (ram_waddr !== 4'd12) begin errors++; $display("FAIL stream_wrap got=%0d exp=12", ram_waddr); end
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin
      errors++; $display("FAIL uf_state got=%b/%0d exp=1/0", empty, usedw); end
    checks++; if (underflow !== ERR_EN) begin
      errors++; $display("FAIL uf_flag got=%b exp=%b", underflow, ERR_EN); end
  endtask

  task automatic test_clear();
    do_reset();
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b1);
    checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin
      errors++; $display("FAIL clr_state got=%b/%0d exp=1/0", empty, usedw); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL clr_errflags got=%b%b exp=00", overflow, underflow); end
    step(1'b1, 16'h00AA, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    checks++; if (empty !== 1'b0 || dataout !== 16'h00AA) begin
      errors++; $display("FAIL clr_next got=%b/%h exp=0/00aa", empty, dataout); end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    checks++; if (usedw !== 5'd15 || full !== 1'b0) begin
      errors++; $display("FAIL frw_usedw got=%0d/%b exp=15/0", usedw, full); end
    checks++; if (dataout !== 16'h3001) begin
      errors++; $display("FAIL frw_head got=%h exp=3001", dataout); end
    for (int i = 0; i < 15; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frw_empty got=%b exp=1", empty); end
  endtask

  initial begin
    for (int i = 0; i < SZ; i++) mem[i] = 16'h0000;
    reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; datain = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_stream();
    test_underflow();
    test_clear();
    test_full_rw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
